fdiv_stream: RTL and testbench
==============================

// Module: fdiv_stream
// PURPOSE
//  Valid/ready streaming front end for the fixed-latency pipelined divider core (fdiv).
//  Accepts tagged operand pairs and drives them into the core, which this block does not
//  instantiate. Tracks in-flight ops in a LAT-deep valid/tag shift register. Captures core
//  results into an output FIFO. Credit-based issue guarantees the FIFO never overflows.
//  Sits between the FPU dispatch stage and the FPU result writeback arbiter.
// PARAMETERS
//  LAT    6  core latency: an op driven in edge-cycle t has its result on div_y sampled at edge t+LAT
//  TAGW   5  width of the opaque destination tag carried alongside each op
//  DEPTH  8  output FIFO entries; also the maximum in-flight + buffered ops (power of 2)
// PORTS
//  clk        in   1     clock
//  rstn       in   1     synchronous reset, active-low
//  in_valid   in   1     operand pair valid
//  in_ready   out  1     block can accept an op this cycle
//  in_a       in   32    dividend, IEEE-754 single
//  in_b       in   32    divisor, IEEE-754 single
//  in_tag     in   TAGW  destination tag
//  div_x1     out  32    to core x1 (dividend)
//  div_x2     out  32    to core x2 (divisor)
//  div_y      in   32    from core y (quotient)
//  out_valid  out  1     result available
//  out_ready  in   1     consumer accepts result
//  out_y      out  32    quotient
//  out_tag    out  TAGW  tag of this result
//  out_dz     out  1     divide-by-zero flag (divisor exponent field == 0)
// BEHAVIOUR
//  - Reset values: in_ready=0, out_valid=0, out_y=0, out_tag=0, out_dz=0. Shift register
//    cleared, FIFO pointers/count=0, inflight=0. In-flight ops are discarded.
//  - Reset mid-operation: core results still emerging after reset are ignored, because the
//    shift-register valids are 0.
//  - Issue: fire = in_valid & in_ready.
//  - in_ready = rstn & (inflight + fifo_count < DEPTH); combinational from registered counts.
//  - div_x1=in_a, div_x2=in_b combinational when fire; both 0 otherwise.
//  - Shift register: stage0 <= {fire, in_tag, in_b[30:23]==0}; stage k <= stage k-1. Its
//    depth makes stage LAT-1 coincide with the edge at which div_y holds that op's result.
//  - Capture: when stage LAT-1 is valid, push {div_y, tag, dz} into the FIFO at that edge.
//  - inflight counts valid entries in the shift register: +1 on fire, -1 on capture,
//    net 0 when both occur.
//  - FIFO: out_* show the head entry; out_valid = (fifo_count != 0).
//  - Pop when out_valid & out_ready. Push and pop in the same cycle are legal in every state,
//    including full: the count is unchanged and ordering is preserved.
//  - Pointers are log2(DEPTH) bits and wrap naturally.
//  - A push into a full FIFO cannot occur by construction; the bench asserts this.
//  - Ordering: results leave in issue order. Throughput 1 op/cycle when out_ready is held 1.
//  - Latency: in fire at edge t -> out_valid high after edge t+LAT (LAT+1 cycles, FIFO empty).
//  - dz is computed from in_b only. Denormal divisors count as zero (FPU flushes denormals).
//    out_y is the core value, unmodified.
//  - in_valid/in_a/in_b/in_tag may change freely while in_ready=0; nothing is latched then.
// TESTING
//  1 single op a=0x40C00000 (6.0), b=0x40000000 (2.0), tag=3 -> out_y=0x40400000, tag=3,
//    dz=0; out_valid rises 7 cycles after fire.
//  2 8 back-to-back ops, tags 0..7, out_ready=1 -> 8 results on consecutive cycles,
//    tags 0..7 in order, in_ready never drops.
//  3 out_ready=0, stream 10 ops -> exactly 8 accepted, then in_ready=0. Raise out_ready ->
//    in_ready returns the cycle after the first pop; all 10 results in order.
//  4 FIFO full, out_ready=1 and new in_valid in the same cycle -> one pop and one fire, count
//    stays 8; no loss or duplication.
//  5 b=0x00000000, then b=0x00400000 (denormal) -> out_dz=1 for both; b=0x3F800000 -> out_dz=0.
//  6 issue 4 ops, deassert rstn for 1 cycle at LAT-2 -> out_valid stays 0, no stale results,
//    in_ready=0 during reset and 1 after.

Source files
------------

// File: rtl/fdiv_stream.sv
// Valid/ready front end for the pipelined fdiv core: issue, in-flight tracking, result FIFO.
// Latency LAT+1 cycles into an empty FIFO; in_ready drops once in-flight + buffered ops reach DEPTH.
module fdiv_stream #(
  parameter int LAT   = 6,
  parameter int TAGW  = 5,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic [31:0]     div_x1,
  output logic [31:0]     div_x2,
  input  logic [31:0]     div_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_y,
  output logic [TAGW-1:0] out_tag,
  output logic            out_dz
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LIMIT = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [AW-1:0] P_ONE = AW'(1);

  typedef struct packed {
    logic            vld;
    logic [TAGW-1:0] tag;
    logic            dz;
  } stage_t;

  typedef struct packed {
    logic [31:0]     y;
    logic [TAGW-1:0] tag;
    logic            dz;
  } entry_t;

  stage_t        sr  [LAT];
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          fire;
  logic          capture;
  logic          pop;

  // Credit check: every in-flight op already owns a FIFO slot, so a capture can never overflow.
  assign in_ready  = rstn && ((inflight + fifo_count) < LIMIT);
  assign fire      = in_valid && in_ready;
  assign capture   = sr[LAT-1].vld;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  assign div_x1 = fire ? in_a : '0;
  assign div_x2 = fire ? in_b : '0;

  assign head    = out_valid ? mem[rptr] : '0;
  assign out_y   = head.y;
  assign out_tag = head.tag;
  assign out_dz  = head.dz;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < LAT; k++) begin
        sr[k] <= '0;
      end
      inflight   <= '0;
      fifo_count <= '0;
      wptr       <= '0;
      rptr       <= '0;
    end else begin
      // Zero exponent covers both true zero and denormals, which the FPU flushes.
      sr[0] <= '{vld: fire, tag: in_tag, dz: (in_b[30:23] == 8'd0)};
      for (int k = 1; k < LAT; k++) begin
        sr[k] <= sr[k-1];
      end

      if (fire && !capture) begin
        inflight <= inflight + C_ONE;
      end else if (!fire && capture) begin
        inflight <= inflight - C_ONE;
      end

      if (capture) begin
        wptr <= wptr + P_ONE;
      end
      if (pop) begin
        rptr <= rptr + P_ONE;
      end

      if (capture && !pop) begin
        fifo_count <= fifo_count + C_ONE;
      end else if (!capture && pop) begin
        fifo_count <= fifo_count - C_ONE;
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rstn && capture) begin
      mem[wptr] <= '{y: div_y, tag: sr[LAT-1].tag, dz: sr[LAT-1].dz};
    end
  end

endmodule

// File: tb/tb_fdiv_stream.sv
// Bench for fdiv_stream: behavioural core model, in-order scoreboard of expected results.
module tb_fdiv_stream;

  localparam int LAT   = 6;
  localparam int TAGW  = 5;
  localparam int DEPTH = 8;

  logic            clk;
  logic            rstn;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_a;
  logic [31:0]     in_b;
  logic [TAGW-1:0] in_tag;
  logic [31:0]     div_x1;
  logic [31:0]     div_x2;
  logic [31:0]     div_y;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_y;
  logic [TAGW-1:0] out_tag;
  logic            out_dz;

  fdiv_stream #(.LAT(LAT), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .div_x1    (div_x1),
    .div_x2    (div_x2),
    .div_y     (div_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .out_dz    (out_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int spurious = 0;
  int max_out = 0;

  logic [37:0] exp_q[$];
  logic [37:0] exp_done[$];
  logic [37:0] got_done[$];
  int          got_cyc[$];
  int          fire_cyc[$];

  logic [31:0]     op_a [16];
  logic [31:0]     op_b [16];
  logic [TAGW-1:0] op_t [16];

  // Core stand-in: exact quotient for power-of-two divisors, an arbitrary mix otherwise.
  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    int e;
    e = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (b[22:0] == 23'd0 && b[30:23] != 8'd0 && b[30:23] != 8'hFF &&
        a[30:23] != 8'd0 && a[30:23] != 8'hFF && e >= 1 && e <= 254)
      return {a[31] ^ b[31], e[7:0], a[22:0]};
    return a ^ {b[15:0], b[31:16]};
  endfunction

  logic [31:0] core_p [LAT];
  always @(posedge clk) begin
    core_p[0] <= quot(div_x1, div_x2);
    for (int k = 1; k < LAT; k++) core_p[k] <= core_p[k-1];
  end
  assign div_y = core_p[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard bookkeeping only; comparisons live in the test tasks.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) spurious++;
        else begin
          exp_done.push_back(exp_q.pop_front());
          got_done.push_back({out_y, out_tag, out_dz});
          got_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({quot(in_a, in_b), in_tag, (in_b[30:23] == 8'h00)});
        fire_cyc.push_back(cyc);
      end
      if (exp_q.size() > max_out) max_out = exp_q.size();
    end
  end

  task automatic clear_logs();
    got_done.delete();
    exp_done.delete();
    got_cyc.delete();
    fire_cyc.delete();
  endtask

  task automatic send(input int first, input int n, input int budget, output int sent);
    int cycles;
    sent = 0;
    cycles = 0;
    while (sent < n && cycles < budget) begin
      in_valid = 1'b1;
      in_a     = op_a[first+sent];
      in_b     = op_b[first+sent];
      in_tag   = op_t[first+sent];
      @(negedge clk);
      if (in_ready) sent++;
      cycles++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    int c;
    c = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    ok = (exp_q.size() == 0);
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000;
    in_tag = 5'd7; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (out_y !== 32'd0) begin n_fail++; $display("FAIL rst_out_y: got %h expected 0", out_y); end
    n_chk++; if (out_tag !== 5'd0) begin n_fail++; $display("FAIL rst_out_tag: got %0d expected 0", out_tag); end
    n_chk++; if (out_dz !== 1'b0) begin n_fail++; $display("FAIL rst_out_dz: got %b expected 0", out_dz); end
    n_chk++; if (div_x1 !== 32'd0 || div_x2 !== 32'd0) begin n_fail++; $display("FAIL rst_div_x: got %h/%h expected 0/0", div_x1, div_x2); end
    @(posedge clk); #1;
    rstn = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_out_valid: got %b expected 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int s; bit ok; logic [37:0] want;
    clear_logs();
    out_ready = 1'b1;
    op_a[0] = 32'h40C00000; op_b[0] = 32'h40000000; op_t[0] = 5'd3;
    want = {32'h40400000, 5'd3, 1'b0};
    send(0, 1, 20, s);
    n_chk++; if (s != 1) begin n_fail++; $display("FAIL single_accept: got %0d expected 1", s); end
    drain(50, ok);
    n_chk++; if (!ok || got_done.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", got_done.size()); end
    if (got_done.size() == 1) begin
      n_chk++; if (got_done[0] !== want) begin n_fail++; $display("FAIL single_result: got %h expected %h", got_done[0], want); end
      n_chk++; if (got_cyc[0] - fire_cyc[0] != LAT + 1) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", got_cyc[0] - fire_cyc[0], LAT + 1); end
    end
  endtask

  task automatic test_back_to_back();
    int s; bit ok;
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin op_a[i] = $urandom; op_b[i] = $urandom; op_t[i] = 5'(i); end
    send(0, 8, 8, s);
    n_chk++; if (s != 8) begin n_fail++; $display("FAIL b2b_accept_no_stall: got %0d expected 8", s); end
    drain(50, ok);
    n_chk++; if (!ok || got_done.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", got_done.size()); end
    for (int i = 0; i < got_done.size(); i++) begin
      n_chk++; if (got_done[i][5:1] !== 5'(i)) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %0d expected %0d", i, got_done[i][5:1], i); end
      n_chk++; if (got_done[i] !== exp_done[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_done[i], exp_done[i]); end
      n_chk++; if (got_cyc[i] != got_cyc[0] + i) begin n_fail++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], got_cyc[0] + i); end
    end
  endtask

  task automatic test_backpressure();
    int s; bit ok; logic r0, r1;
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin op_a[i] = $urandom; op_b[i] = $urandom; op_t[i] = 5'(i); end
    send(0, 10, 30, s);
    n_chk++; if (s != DEPTH) begin n_fail++; $display("FAIL bp_accepted: got %0d expected %0d", s, DEPTH); end
    in_valid = 1'b1; in_a = op_a[8]; in_b = op_b[8]; in_tag = op_t[8];
    out_ready = 1'b1;
    @(negedge clk); r0 = in_ready;
    @(posedge clk); #1;
    @(negedge clk); r1 = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_chk++; if (r0 !== 1'b0) begin n_fail++; $display("FAIL bp_ready_before_pop: got %b expected 0", r0); end
    n_chk++; if (r1 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b expected 1", r1); end
    send(9, 1, 20, s);
    n_chk++; if (s != 1) begin n_fail++; $display("FAIL bp_last_accept: got %0d expected 1", s); end
    drain(80, ok);
    n_chk++; if (!ok || got_done.size() != 10) begin n_fail++; $display("FAIL bp_count: got %0d expected 10", got_done.size()); end
    for (int i = 0; i < got_done.size(); i++) begin
      n_chk++; if (got_done[i][5:1] !== 5'(i)) begin n_fail++; $display("FAIL bp_tag[%0d]: got %0d expected %0d", i, got_done[i][5:1], i); end
      n_chk++; if (got_done[i] !== exp_done[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", i, got_done[i], exp_done[i]); end
    end
  endtask

  task automatic test_full_pushpop();
    int s; bit ok; logic p0, r1;
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin op_a[i] = $urandom; op_b[i] = $urandom; op_t[i] = 5'(20 + i); end
    send(0, 8, 8, s);
    n_chk++; if (s != 8) begin n_fail++; $display("FAIL full_fill: got %0d expected 8", s); end
    repeat (LAT + 2) begin @(posedge clk); #1; end
    out_ready = 1'b1; in_valid = 1'b1; in_a = op_a[8]; in_b = op_b[8]; in_tag = op_t[8];
    @(negedge clk); p0 = out_valid;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk); r1 = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_chk++; if (p0 !== 1'b1) begin n_fail++; $display("FAIL full_pop_valid: got %b expected 1", p0); end
    n_chk++; if (r1 !== 1'b1) begin n_fail++; $display("FAIL full_refill_ready: got %b expected 1", r1); end
    n_chk++; if (exp_q.size() != DEPTH) begin n_fail++; $display("FAIL full_outstanding: got %0d expected %0d", exp_q.size(), DEPTH); end
    repeat (LAT + 2) begin @(posedge clk); #1; end
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL full_again: got ready=%b valid=%b expected 0/1", in_ready, out_valid); end
    @(posedge clk); #1;
    drain(60, ok);
    n_chk++; if (!ok || got_done.size() != 9) begin n_fail++; $display("FAIL full_count: got %0d expected 9", got_done.size()); end
    for (int i = 0; i < got_done.size(); i++) begin
      n_chk++; if (got_done[i][5:1] !== 5'(20 + i)) begin n_fail++; $display("FAIL full_tag[%0d]: got %0d expected %0d", i, got_done[i][5:1], 20 + i); end
      n_chk++; if (got_done[i] !== exp_done[i]) begin n_fail++; $display("FAIL full_data[%0d]: got %h expected %h", i, got_done[i], exp_done[i]); end
    end
  endtask

  task automatic test_dz();
    int s; bit ok; logic want_dz [3];
    clear_logs();
    out_ready = 1'b1;
    op_b[0] = 32'h00000000; op_b[1] = 32'h00400000; op_b[2] = 32'h3F800000;
    want_dz[0] = 1'b1; want_dz[1] = 1'b1; want_dz[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin op_a[i] = {1'b0, 8'h80, 23'($urandom)}; op_t[i] = 5'(i + 1); end
    send(0, 3, 10, s);
    drain(40, ok);
    n_chk++; if (!ok || got_done.size() != 3) begin n_fail++; $display("FAIL dz_count: got %0d expected 3", got_done.size()); end
    for (int i = 0; i < got_done.size(); i++) begin
      n_chk++; if (got_done[i][0] !== want_dz[i]) begin n_fail++; $display("FAIL dz_flag[%0d]: got %b expected %b", i, got_done[i][0], want_dz[i]); end
      n_chk++; if (got_done[i] !== exp_done[i]) begin n_fail++; $display("FAIL dz_data[%0d]: got %h expected %h", i, got_done[i], exp_done[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    int s; int vcnt;
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin op_a[i] = $urandom; op_b[i] = $urandom; op_t[i] = 5'(i); end
    send(0, 4, 4, s);
    n_chk++; if (s != 4) begin n_fail++; $display("FAIL mrst_accept: got %0d expected 4", s); end
    rstn = 1'b0;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_ready_low: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    rstn = 1'b1;
    vcnt = 0;
    repeat (2 * LAT + 2) begin
      @(negedge clk);
      if (out_valid) vcnt++;
      @(posedge clk); #1;
    end
    n_chk++; if (vcnt != 0) begin n_fail++; $display("FAIL mrst_stale_valid: got %0d cycles expected 0", vcnt); end
    n_chk++; if (got_done.size() != 0 || spurious != 0) begin n_fail++; $display("FAIL mrst_stale_results: got %0d/%0d expected 0/0", got_done.size(), spurious); end
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_ready_after: got %b expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit ok;
    clear_logs();
    max_out = 0;
    for (int c = 0; c < 500; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = $urandom;
      in_b      = ($urandom_range(0, 7) == 0) ? ($urandom & 32'h807FFFFF) : $urandom;
      in_tag    = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain(100, ok);
    n_chk++; if (!ok || got_done.size() != fire_cyc.size()) begin n_fail++; $display("FAIL rnd_count: got %0d expected %0d", got_done.size(), fire_cyc.size()); end
    for (int i = 0; i < got_done.size(); i++) begin
      n_chk++; if (got_done[i] !== exp_done[i]) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, got_done[i], exp_done[i]); end
    end
    n_chk++; if (max_out > DEPTH) begin n_fail++; $display("FAIL rnd_overcommit: got %0d expected <= %0d", max_out, DEPTH); end
    n_chk++; if (spurious != 0) begin n_fail++; $display("FAIL rnd_spurious: got %0d expected 0", spurious); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_pushpop();
    test_dz();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
